posmap_walk_sequencer: RTL and testbench

Sequences multi-level position-map lookups through the PosMap+PLB unit (PPP) on behalf of the frontend. Each program request is probed level by level until the PPP hits, then the walk comes back down: the sequencer fetches each missing PosMap block from the backend, refills it into the PPP, and re-probes. It returns the remapped leaf (old and new) of the data block. It sits between the frontend request port, the PPP command/response port and the backend access queue.

---
 rtl/posmap_walk_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_posmap_walk_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posmap_walk_sequencer.sv
// Walks the PosMap hierarchy for one program request. It probes upward until the PPP hits,
// then fetches and refills each missing PosMap block on the way back down.
module posmap_walk_sequencer #(
  parameter int ORAMU          = 32,
  parameter int ORAML          = 32,
  parameter int LogLeafInBlock = 4,
  parameter int NumLevels      = 3,
  parameter logic [NumLevels*ORAMU-1:0] LevelBases = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [ORAMU-1:0] i_req_addr,
  output logic             o_leaf_valid,
  input  logic             i_leaf_ready,
  output logic [ORAML-1:0] o_old_leaf,
  output logic [ORAML-1:0] o_new_leaf,
  output logic             o_uninit,
  output logic             o_ppp_cmd_valid,
  input  logic             i_ppp_cmd_ready,
  output logic [1:0]       o_ppp_cmd,
  output logic [ORAMU-1:0] o_ppp_addr,
  input  logic             i_ppp_out_valid,
  output logic             o_ppp_out_ready,
  input  logic             i_ppp_hit,
  input  logic             i_ppp_uninit,
  input  logic             i_ppp_evict,
  input  logic [ORAML-1:0] i_ppp_old_leaf,
  input  logic [ORAML-1:0] i_ppp_new_leaf,
  input  logic [ORAMU-1:0] i_ppp_addr_out,
  output logic             o_be_req_valid,
  input  logic             i_be_req_ready,
  output logic [ORAMU-1:0] o_be_req_addr,
  output logic [ORAML-1:0] o_be_req_old_leaf,
  output logic [ORAML-1:0] o_be_req_new_leaf,
  output logic             o_be_req_init,
  output logic             o_be_req_wb,
  input  logic             i_be_data_ready,
  output logic             o_error
);

  localparam int LW = (NumLevels > 1) ? $clog2(NumLevels) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PROBE, S_PROBE_WAIT, S_BE_REQ, S_BE_WAIT,
    S_REFILL, S_REFILL_WAIT, S_WB, S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [ORAMU-1:0] r_addr;
  logic [LW-1:0]    r_level;
  logic [ORAML-1:0] r_old_leaf, r_new_leaf;
  logic             r_uninit;
  logic [ORAMU-1:0] r_wb_addr;
  logic [ORAML-1:0] r_wb_leaf;
  logic             r_error;

  logic [ORAMU-1:0] w_level_addr [NumLevels];
  logic [ORAMU-1:0] w_addr_cur, w_addr_prev;
  logic             w_last_level;

  assign w_level_addr[0] = r_addr;
  generate
    for (genvar gi = 1; gi < NumLevels; gi++) begin : g_level_addr
      assign w_level_addr[gi] = LevelBases[gi*ORAMU +: ORAMU] + (r_addr >> (gi*LogLeafInBlock));
    end
  endgenerate

  always_comb begin
    w_addr_cur  = '0;
    w_addr_prev = '0;
    for (int i = 0; i < NumLevels; i++) begin
      if (r_level == LW'(i)) w_addr_cur = w_level_addr[i];
    end
    for (int i = 1; i < NumLevels; i++) begin
      if (r_level == LW'(i)) w_addr_prev = w_level_addr[i-1];
    end
  end

  assign w_last_level = (r_level == LW'(NumLevels - 1));
  assign o_error      = r_error;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    o_req_ready       = 1'b0;
    o_leaf_valid      = 1'b0;
    o_old_leaf        = '0;
    o_new_leaf        = '0;
    o_uninit          = 1'b0;
    o_ppp_cmd_valid   = 1'b0;
    o_ppp_cmd         = 2'b00;
    o_ppp_addr        = '0;
    o_ppp_out_ready   = 1'b0;
    o_be_req_valid    = 1'b0;
    o_be_req_addr     = '0;
    o_be_req_old_leaf = '0;
    o_be_req_new_leaf = '0;
    o_be_req_init     = 1'b0;
    o_be_req_wb       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_next = S_PROBE;
      end
      S_PROBE: begin
        o_ppp_cmd_valid = 1'b1;
        o_ppp_cmd       = 2'b01;
        o_ppp_addr      = w_addr_cur;
        if (i_ppp_cmd_ready) w_state_next = S_PROBE_WAIT;
      end
      S_PROBE_WAIT: begin
        o_ppp_out_ready = 1'b1;
        if (i_ppp_out_valid) begin
          if (!i_ppp_hit)            w_state_next = w_last_level ? S_IDLE : S_PROBE;
          else if (r_level == '0)    w_state_next = S_DONE;
          else                       w_state_next = S_BE_REQ;
        end
      end
      S_BE_REQ: begin
        o_be_req_valid    = 1'b1;
        o_be_req_addr     = w_addr_cur;
        o_be_req_old_leaf = r_old_leaf;
        o_be_req_new_leaf = r_new_leaf;
        o_be_req_init     = r_uninit;
        if (i_be_req_ready) w_state_next = S_BE_WAIT;
      end
      S_BE_WAIT: begin
        if (i_be_data_ready) w_state_next = S_REFILL;
      end
      S_REFILL: begin
        o_ppp_cmd_valid = 1'b1;
        o_ppp_cmd       = r_uninit ? 2'b11 : 2'b10;
        o_ppp_addr      = w_addr_prev;
        if (i_ppp_cmd_ready) w_state_next = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        o_ppp_out_ready = 1'b1;
        if (i_ppp_out_valid) w_state_next = i_ppp_evict ? S_WB : S_PROBE;
      end
      S_WB: begin
        // Eviction fields were latched so they stay stable while the backend stalls.
        o_be_req_valid    = 1'b1;
        o_be_req_addr     = r_wb_addr;
        o_be_req_new_leaf = r_wb_leaf;
        o_be_req_wb       = 1'b1;
        if (i_be_req_ready) w_state_next = S_PROBE;
      end
      S_DONE: begin
        o_leaf_valid = 1'b1;
        o_old_leaf   = r_old_leaf;
        o_new_leaf   = r_new_leaf;
        o_uninit     = r_uninit;
        if (i_leaf_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_level    <= '0;
      r_old_leaf <= '0;
      r_new_leaf <= '0;
      r_uninit   <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_leaf  <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_addr  <= i_req_addr;
            r_level <= '0;
          end
        end
        S_PROBE_WAIT: begin
          if (i_ppp_out_valid) begin
            if (!i_ppp_hit) begin
              if (w_last_level) r_error <= 1'b1;
              else              r_level <= r_level + LW'(1);
            end else begin
              r_old_leaf <= i_ppp_old_leaf;
              r_new_leaf <= i_ppp_new_leaf;
              r_uninit   <= i_ppp_uninit;
            end
          end
        end
        S_REFILL_WAIT: begin
          if (i_ppp_out_valid) begin
            if (i_ppp_evict) begin
              r_wb_addr <= i_ppp_addr_out;
              r_wb_leaf <= i_ppp_new_leaf;
            end else begin
              r_level <= r_level - LW'(1);
            end
          end
        end
        S_WB: begin
          if (i_be_req_ready) r_level <= r_level - LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posmap_walk_sequencer.sv
// Bench for posmap_walk_sequencer: plays PPP, backend and frontend in one directed sequence,
// with expected traffic derived from the level-address rule and a per-walk plan.
module tb_posmap_walk_sequencer;

  localparam int U = 16;
  localparam int L = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [U-1:0]  i_req_addr = '0;
  logic          o_leaf_valid;
  logic          i_leaf_ready = 1'b0;
  logic [L-1:0]  o_old_leaf, o_new_leaf;
  logic          o_uninit;
  logic          o_ppp_cmd_valid;
  logic          i_ppp_cmd_ready = 1'b0;
  logic [1:0]    o_ppp_cmd;
  logic [U-1:0]  o_ppp_addr;
  logic          i_ppp_out_valid = 1'b0;
  logic          o_ppp_out_ready;
  logic          i_ppp_hit = 1'b0, i_ppp_uninit = 1'b0, i_ppp_evict = 1'b0;
  logic [L-1:0]  i_ppp_old_leaf = '0, i_ppp_new_leaf = '0;
  logic [U-1:0]  i_ppp_addr_out = '0;
  logic          o_be_req_valid;
  logic          i_be_req_ready = 1'b0;
  logic [U-1:0]  o_be_req_addr;
  logic [L-1:0]  o_be_req_old_leaf, o_be_req_new_leaf;
  logic          o_be_req_init, o_be_req_wb;
  logic          i_be_data_ready = 1'b0;
  logic          o_error;

  int   n_vec = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;

  posmap_walk_sequencer #(
    .ORAMU(U), .ORAML(L), .LogLeafInBlock(4), .NumLevels(3),
    .LevelBases({16'hC000, 16'h8000, 16'h0000})
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .o_leaf_valid(o_leaf_valid), .i_leaf_ready(i_leaf_ready),
    .o_old_leaf(o_old_leaf), .o_new_leaf(o_new_leaf), .o_uninit(o_uninit),
    .o_ppp_cmd_valid(o_ppp_cmd_valid), .i_ppp_cmd_ready(i_ppp_cmd_ready),
    .o_ppp_cmd(o_ppp_cmd), .o_ppp_addr(o_ppp_addr),
    .i_ppp_out_valid(i_ppp_out_valid), .o_ppp_out_ready(o_ppp_out_ready),
    .i_ppp_hit(i_ppp_hit), .i_ppp_uninit(i_ppp_uninit), .i_ppp_evict(i_ppp_evict),
    .i_ppp_old_leaf(i_ppp_old_leaf), .i_ppp_new_leaf(i_ppp_new_leaf),
    .i_ppp_addr_out(i_ppp_addr_out),
    .o_be_req_valid(o_be_req_valid), .i_be_req_ready(i_be_req_ready),
    .o_be_req_addr(o_be_req_addr), .o_be_req_old_leaf(o_be_req_old_leaf),
    .o_be_req_new_leaf(o_be_req_new_leaf), .o_be_req_init(o_be_req_init),
    .o_be_req_wb(o_be_req_wb), .i_be_data_ready(i_be_data_ready), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Level i address: base_i + (addr >> 4i); level 0 is the data block itself.
  function automatic logic [U-1:0] lvl_addr(input logic [U-1:0] a, input int i);
    if (i == 0) return a;
    return ((i == 1) ? 16'h8000 : 16'hC000) + (a >> (4 * i));
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0: return o_ppp_cmd_valid;
      1: return o_be_req_valid;
      2: return o_leaf_valid;
      3: return o_ppp_out_ready;
      default: return o_req_ready;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, 32'(sig(which)), 32'd1);
  endtask

  task automatic stall();
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
  endtask

  task automatic send_req(input logic [U-1:0] a);
    wait_sig(4, "req_ready");
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_addr  = 16'($urandom);
    @(negedge i_clk);
  endtask

  task automatic ppp_cmd(input logic [1:0] c, input logic [U-1:0] a, input string tag);
    wait_sig(0, {tag, "_cmd_valid"});
    stall();
    chk({tag, "_cmd"},  32'(o_ppp_cmd),  32'(c));
    chk({tag, "_addr"}, 32'(o_ppp_addr), 32'(a));
    i_ppp_cmd_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ppp_cmd_ready = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic ppp_resp(input logic h, input logic u, input logic e,
                          input logic [L-1:0] ol, input logic [L-1:0] nl, input logic [U-1:0] ao);
    stall();
    i_ppp_out_valid = 1'b1;
    i_ppp_hit = h; i_ppp_uninit = u; i_ppp_evict = e;
    i_ppp_old_leaf = ol; i_ppp_new_leaf = nl; i_ppp_addr_out = ao;
    wait_sig(3, "ppp_out_ready");
    @(posedge i_clk); #1;
    i_ppp_out_valid = 1'b0;
    i_ppp_hit = 1'($urandom); i_ppp_uninit = 1'($urandom); i_ppp_evict = 1'($urandom);
    i_ppp_old_leaf = 16'($urandom); i_ppp_new_leaf = 16'($urandom); i_ppp_addr_out = 16'($urandom);
    @(negedge i_clk);
  endtask

  task automatic be_req(input logic [U-1:0] a, input logic [L-1:0] ol, input logic [L-1:0] nl,
                        input logic init, input logic wb, input string tag);
    wait_sig(1, {tag, "_valid"});
    stall();
    chk({tag, "_addr"}, 32'(o_be_req_addr),     32'(a));
    chk({tag, "_old"},  32'(o_be_req_old_leaf), 32'(ol));
    chk({tag, "_new"},  32'(o_be_req_new_leaf), 32'(nl));
    chk({tag, "_init"}, 32'(o_be_req_init),     32'(init));
    chk({tag, "_wb"},   32'(o_be_req_wb),       32'(wb));
    i_be_req_ready = 1'b1;
    @(posedge i_clk); #1;
    i_be_req_ready = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic be_data();
    stall();
    chk("be_wait_no_cmd", 32'(o_ppp_cmd_valid), 32'd0);
    chk("be_wait_no_req", 32'(o_be_req_valid),  32'd0);
    i_be_data_ready = 1'b1;
    @(posedge i_clk); #1;
    i_be_data_ready = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic leaf(input logic [L-1:0] ol, input logic [L-1:0] nl, input logic u);
    wait_sig(2, "leaf_valid");
    stall();
    chk("leaf_old",    32'(o_old_leaf), 32'(ol));
    chk("leaf_new",    32'(o_new_leaf), 32'(nl));
    chk("leaf_uninit", 32'(o_uninit),   32'(u));
    chk("leaf_error",  32'(o_error),    32'(err_exp));
    i_leaf_ready = 1'b1;
    @(posedge i_clk); #1;
    i_leaf_ready = 1'b0;
    @(negedge i_clk);
    chk("idle_after_leaf", 32'(o_req_ready), 32'd1);
  endtask

  // hl = level that hits (3 = nothing hits); first refill uses ev/ea/el, later ones are random.
  task automatic walk(input logic [U-1:0] a, input int hl, input logic uh,
                      input logic [L-1:0] ho, input logic [L-1:0] hn,
                      input logic ev, input logic [U-1:0] ea, input logic [L-1:0] el,
                      input logic [L-1:0] fo, input logic [L-1:0] fn, input logic fu);
    int lvl;
    logic [L-1:0] o, n;
    logic u, e;
    logic [U-1:0] eaddr;
    logic [L-1:0] eleaf;
    $display("walk addr=%04h hit_level=%0d uninit=%0b evict=%0b", a, hl, uh, ev);
    send_req(a);
    for (int i = 0; i <= hl && i < 3; i++) begin
      ppp_cmd(2'b01, lvl_addr(a, i), "probe");
      if (i == hl) ppp_resp(1'b1, uh, 1'b0, ho, hn, 16'($urandom));
      else         ppp_resp(1'b0, 1'($urandom), 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    if (hl >= 3) begin
      err_exp = 1'b1;
      chk("top_miss_error",   32'(o_error),      32'd1);
      chk("top_miss_no_leaf", 32'(o_leaf_valid), 32'd0);
      chk("top_miss_idle",    32'(o_req_ready),  32'd1);
      return;
    end
    lvl = hl; o = ho; n = hn; u = uh;
    while (lvl > 0) begin
      be_req(lvl_addr(a, lvl), o, n, u, 1'b0, "be_fetch");
      be_data();
      ppp_cmd(u ? 2'b11 : 2'b10, lvl_addr(a, lvl - 1), "refill");
      e     = (lvl == hl) ? ev : 1'($urandom);
      eaddr = (lvl == hl) ? ea : 16'($urandom);
      eleaf = (lvl == hl) ? el : 16'($urandom);
      ppp_resp(1'($urandom), 1'($urandom), e, 16'($urandom), eleaf, eaddr);
      if (e) be_req(eaddr, '0, eleaf, 1'b0, 1'b1, "be_wb");
      lvl--;
      ppp_cmd(2'b01, lvl_addr(a, lvl), "reprobe");
      if (lvl == 0) begin o = fo; n = fn; u = fu; end
      else begin o = 16'($urandom); n = 16'($urandom); u = 1'($urandom); end
      ppp_resp(1'b1, u, 1'b0, o, n, 16'($urandom));
    end
    leaf(o, n, u);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_leaf_valid"}, 32'(o_leaf_valid),    32'd0);
    chk({tag, "_cmd_valid"},  32'(o_ppp_cmd_valid), 32'd0);
    chk({tag, "_out_ready"},  32'(o_ppp_out_ready), 32'd0);
    chk({tag, "_be_valid"},   32'(o_be_req_valid),  32'd0);
    chk({tag, "_error"},      32'(o_error),         32'd0);
    chk({tag, "_ppp_addr"},   32'(o_ppp_addr),      32'd0);
    chk({tag, "_be_addr"},    32'(o_be_req_addr),   32'd0);
    chk({tag, "_leaves"},     32'({o_old_leaf, o_new_leaf}), 32'd0);
  endtask

  initial begin
    logic [U-1:0] ra;
    repeat (2) @(negedge i_clk);
    chk_quiet("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Level-0 hit with always-ready PPP: LeafValid three cycles after the accept.
    $display("walk addr=1234 hit_level=0 latency");
    i_req_valid = 1'b1; i_req_addr = 16'h1234;
    i_ppp_cmd_ready = 1'b1; i_ppp_out_valid = 1'b1; i_ppp_hit = 1'b1;
    i_ppp_uninit = 1'b0; i_ppp_evict = 1'b0; i_ppp_old_leaf = 16'd5; i_ppp_new_leaf = 16'd9;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("l0_cmd",  32'(o_ppp_cmd),  32'd1);
    chk("l0_addr", 32'(o_ppp_addr), 32'h1234);
    chk("l0_c1_leaf", 32'(o_leaf_valid), 32'd0);
    @(negedge i_clk);
    chk("l0_c2_leaf",  32'(o_leaf_valid),    32'd0);
    chk("l0_one_cmd",  32'(o_ppp_cmd_valid), 32'd0);
    @(negedge i_clk);
    chk("l0_c3_leaf", 32'(o_leaf_valid), 32'd1);
    i_ppp_cmd_ready = 1'b0; i_ppp_out_valid = 1'b0;
    chk("l0_old", 32'(o_old_leaf), 32'd5);
    chk("l0_new", 32'(o_new_leaf), 32'd9);
    chk("l0_uninit", 32'(o_uninit), 32'd0);
    i_leaf_ready = 1'b1;
    @(posedge i_clk); #1;
    i_leaf_ready = 1'b0;
    @(negedge i_clk);
    chk("l0_back_idle", 32'(o_req_ready), 32'd1);

    walk(16'h1234, 1, 1'b0, 16'd7, 16'd3, 1'b0, 16'h0, 16'h0, 16'd5, 16'd9, 1'b0);
    walk(16'h1234, 1, 1'b1, 16'd7, 16'd3, 1'b0, 16'h0, 16'h0, 16'd2, 16'd4, 1'b1);
    walk(16'h1234, 1, 1'b0, 16'd7, 16'd3, 1'b1, 16'h4560, 16'hA, 16'd5, 16'd9, 1'b0);
    walk(16'hBEEF, 2, 1'b1, 16'h11, 16'h22, 1'b1, 16'h0777, 16'h33, 16'h44, 16'h55, 1'b0);
    walk(16'h1234, 3, 1'b0, 16'd0, 16'd0, 1'b0, 16'h0, 16'h0, 16'd0, 16'd0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      ra = 16'($urandom);
      walk(ra, (k % 7 == 6) ? 3 : int'($urandom_range(0, 2)), 1'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Reset while waiting on backend data; Error must clear too.
    $display("walk addr=2468 reset during backend wait");
    send_req(16'h2468);
    ppp_cmd(2'b01, lvl_addr(16'h2468, 0), "rst_probe0");
    ppp_resp(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    ppp_cmd(2'b01, lvl_addr(16'h2468, 1), "rst_probe1");
    ppp_resp(1'b1, 1'b0, 1'b0, 16'h66, 16'h77, 16'h0);
    be_req(lvl_addr(16'h2468, 1), 16'h66, 16'h77, 1'b0, 1'b0, "rst_be");
    i_rst = 1'b1;
    #1;
    chk_quiet("midreset");
    chk("midreset_idle", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    err_exp = 1'b0;
    @(negedge i_clk);
    chk("post_reset_no_be", 32'(o_be_req_valid), 32'd0);
    walk(16'h2468, 1, 1'b0, 16'h12, 16'h34, 1'b0, 16'h0, 16'h0, 16'h56, 16'h78, 1'b0);
    walk(16'h0F0F, 0, 1'b1, 16'h9, 16'h8, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
